// File: rtl/serial_frame_rx.sv
// Serial display/LED link receiver: rebuilds FRAME_BITS-bit frames shifted in on ser_clk/ser_dt.
// Optional macro SERIAL_FRAME_RX_GLITCH_FILTER_EN requires ser_clk high for >=2 clk per edge.
module serial_frame_rx #(
  parameter int FRAME_BITS  = 64,
  parameter int IDLE_CYCLES = 4096,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ser_clk,
  input  logic                  ser_dt,
  input  logic                  ser_clr_n,
  output logic [FRAME_BITS-1:0] frame_data,
  output logic                  frame_valid,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [IW-1:0]           idle_cnt_q, idle_cnt_d;
  logic [FRAME_BITS-1:0]   sr_q, sr_d;
  logic [FRAME_BITS-1:0]   frame_data_q, frame_data_d;
  logic                    frame_err_q, frame_err_d;

  logic clk_s1_q, clk_s2_q, clk_s3_q;
  logic dt_s1_q, dt_s2_q;
  logic clr_s1_q, clr_s2_q;
  logic ser_edge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1_q <= 1'b0;
      clk_s2_q <= 1'b0;
      clk_s3_q <= 1'b0;
      dt_s1_q  <= 1'b0;
      dt_s2_q  <= 1'b0;
      clr_s1_q <= 1'b0;
      clr_s2_q <= 1'b0;
    end else begin
      clk_s1_q <= ser_clk;
      clk_s2_q <= clk_s1_q;
      clk_s3_q <= clk_s2_q;
      dt_s1_q  <= ser_dt;
      dt_s2_q  <= dt_s1_q;
      clr_s1_q <= ser_clr_n;
      clr_s2_q <= clr_s1_q;
    end
  end

`ifdef SERIAL_FRAME_RX_GLITCH_FILTER_EN
  logic clk_s4_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s4_q <= 1'b0;
    end else begin
      clk_s4_q <= clk_s3_q;
    end
  end

  // A rise only counts once ser_clk has been seen high on two consecutive clocks.
  assign ser_edge = clk_s2_q & clk_s3_q & ~clk_s4_q;
`else
  assign ser_edge = clk_s2_q & ~clk_s3_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      idle_cnt_q   <= '0;
      sr_q         <= '0;
      frame_data_q <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      sr_q         <= sr_d;
      frame_data_q <= frame_data_d;
      frame_err_q  <= frame_err_d;
    end
  end

  logic [FRAME_BITS-1:0] sr_shift;
  logic [IW-1:0]         idle_inc;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    sr_d         = sr_q;
    frame_data_d = frame_data_q;
    frame_err_d  = 1'b0;

    sr_shift = MSB_FIRST ? {sr_q[FRAME_BITS-2:0], dt_s2_q}
                         : {dt_s2_q, sr_q[FRAME_BITS-1:1]};
    idle_inc = (idle_cnt_q == IDLE_MAX) ? idle_cnt_q : idle_cnt_q + 1'b1;

    if (!clr_s2_q) begin
      state_d    = ST_IDLE;
      bit_cnt_d  = '0;
      idle_cnt_d = '0;
      sr_d       = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_RECV: begin
          if (ser_edge) begin
            sr_d       = sr_shift;
            idle_cnt_d = '0;
            if (bit_cnt_q == LAST_BIT) begin
              // Frame output is loaded here so it changes together with the valid pulse.
              frame_data_d = sr_shift;
              bit_cnt_d    = BW'(FRAME_BITS);
              state_d      = ST_DONE;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
              state_d   = ST_RECV;
            end
          end else if (state_q == ST_RECV) begin
            if (idle_inc == IDLE_MAX) begin
              frame_err_d = 1'b1;
              bit_cnt_d   = '0;
              idle_cnt_d  = '0;
              sr_d        = '0;
              state_d     = ST_IDLE;
            end else begin
              idle_cnt_d = idle_inc;
            end
          end
        end
        ST_DONE: begin
          bit_cnt_d  = '0;
          idle_cnt_d = '0;
          sr_d       = '0;
          state_d    = ST_IDLE;
        end
        default: begin
          state_d   = ST_IDLE;
          bit_cnt_d = '0;
          sr_d      = '0;
        end
      endcase
    end
  end

  assign frame_data  = frame_data_q;
  assign frame_valid = (state_q == ST_DONE);
  assign frame_err   = frame_err_q;
  assign busy        = (state_q == ST_RECV);

endmodule
